// File: rtl/AluCtrlSig_pkg.sv
// Opcode constants shared by the instruction checker and its scoreboard.
// Values are the primary opcode field, inst[31:26].
package AluCtrlSig_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/chk_tally_pkg.sv
// Types shared by the checker tally stage: class enum, FSM states,
// delay-line entry and the opcode-to-class decode.
package chk_tally_pkg;

    import AluCtrlSig_pkg::*;

    typedef enum logic [2:0] {
        CLS_R     = 3'd0,
        CLS_ADDI  = 3'd1,
        CLS_LW    = 3'd2,
        CLS_SW    = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_BNE   = 3'd5,
        CLS_J     = 3'd6,
        CLS_OTHER = 3'd7
    } chk_cls_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tally_st_t;

    typedef struct packed {
        logic        vld;
        chk_cls_t    cls;
        logic [31:0] inst;
    } dly_ent_t;

    function automatic chk_cls_t decode_cls(input logic [5:0] op);
        chk_cls_t c;
        c = CLS_OTHER;
        unique case (1'b1)
            (op == OP_RTYPE): c = CLS_R;
            (op == OP_ADDI):  c = CLS_ADDI;
            (op == OP_LW):    c = CLS_LW;
            (op == OP_SW):    c = CLS_SW;
            (op == OP_BEQ):   c = CLS_BEQ;
            (op == OP_BNE):   c = CLS_BNE;
            (op == OP_J):     c = CLS_J;
            default:          c = CLS_OTHER;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/chk_align_dly.sv
// Fixed-depth delay line that lines each issued instruction up with
// the checker verdict produced DEPTH cycles later.
module chk_align_dly
    import chk_tally_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic     clk,
    input  logic     reset,
    input  dly_ent_t i_ent,
    output dly_ent_t o_ent
);

    dly_ent_t r_pipe [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_ent;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_ent = r_pipe[DEPTH-1];

endmodule

// File: rtl/chk_tally.sv
// Scoreboard tally behind the instruction checker: per-class pass/fail
// counts, first-failure capture, watchdog/abort policing, final verdict.
module chk_tally
    import chk_tally_pkg::*;
#(
    parameter int CHK_LAT   = 3,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 64,
    parameter int MAX_CFAIL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst,
    input  logic             pcEn,
    input  logic             OpDone,
    input  logic             start,
    input  logic             stop,
    input  logic [2:0]       cls_sel,
    output logic [CNT_W-1:0] cls_pass,
    output logic [CNT_W-1:0] cls_fail,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] spur_cnt,
    output logic [31:0]      first_fail_inst,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic             abort,
    output logic             timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int CF_W = $clog2(MAX_CFAIL + 1);
    localparam int DR_W = (CHK_LAT > 1) ? $clog2(CHK_LAT + 1) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    tally_st_t        r_st;
    tally_st_t        w_st_nxt;

    dly_ent_t         w_in;
    dly_ent_t         w_tail;

    logic [CNT_W-1:0] r_pass [8];
    logic [CNT_W-1:0] r_fail [8];
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_fcnt;
    logic [CNT_W-1:0] r_spur;
    logic [31:0]      r_ff_inst;
    logic [CNT_W-1:0] r_ff_idx;
    logic [WD_W-1:0]  r_wd;
    logic [CF_W-1:0]  r_cf;
    logic [DR_W-1:0]  r_dr;
    logic             r_abort;
    logic             r_tmo;

    logic             w_ret_ok;
    logic             w_ret_bad;
    logic             w_spur;
    logic             w_wd_hit;
    logic             w_cf_hit;
    logic             w_dr_last;

    logic             w_clr;
    logic             w_cnt_en;
    logic             w_wd_en;
    logic             w_dr_en;

    always_comb begin
        w_in      = '0;
        w_in.vld  = pcEn;
        w_in.cls  = decode_cls(inst[31:26]);
        w_in.inst = inst;
    end

    chk_align_dly #(
        .DEPTH (CHK_LAT)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .i_ent (w_in),
        .o_ent (w_tail)
    );

    assign w_ret_ok  = w_tail.vld & OpDone;
    assign w_ret_bad = w_tail.vld & ~OpDone;
    assign w_spur    = ~w_tail.vld & OpDone;

    // Policing only fires in RUN; DRAIN keeps counting but never aborts.
    assign w_wd_hit  = (r_st == ST_RUN) & ~w_tail.vld
                     & ((r_wd + 1'b1) == WD_W'(TIMEOUT));
    assign w_cf_hit  = (r_st == ST_RUN) & w_ret_bad
                     & ((r_cf + 1'b1) == CF_W'(MAX_CFAIL));
    assign w_dr_last = (r_dr == DR_W'(CHK_LAT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st <= ST_IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_comb begin
        w_st_nxt = r_st;
        unique case (r_st)
            ST_IDLE: begin
                if (start) w_st_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_wd_hit | w_cf_hit) w_st_nxt = ST_DONE;
                else if (stop)           w_st_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_dr_last) w_st_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (start) w_st_nxt = ST_RUN;
            end
            default: w_st_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_clr    = 1'b0;
        w_cnt_en = 1'b0;
        w_wd_en  = 1'b0;
        w_dr_en  = 1'b0;
        unique case (r_st)
            ST_IDLE:  w_clr = start;
            ST_RUN: begin
                w_cnt_en = 1'b1;
                w_wd_en  = 1'b1;
            end
            ST_DRAIN: begin
                w_cnt_en = 1'b1;
                w_dr_en  = 1'b1;
            end
            ST_DONE:  w_clr = start;
            default:  w_clr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_pass[i] <= '0;
                r_fail[i] <= '0;
            end
            r_total   <= '0;
            r_fcnt    <= '0;
            r_spur    <= '0;
            r_ff_inst <= '0;
            r_ff_idx  <= '0;
            r_wd      <= '0;
            r_cf      <= '0;
            r_dr      <= '0;
            r_abort   <= 1'b0;
            r_tmo     <= 1'b0;
        end else if (w_clr) begin
            for (int i = 0; i < 8; i++) begin
                r_pass[i] <= '0;
                r_fail[i] <= '0;
            end
            r_total   <= '0;
            r_fcnt    <= '0;
            r_spur    <= '0;
            r_ff_inst <= '0;
            r_ff_idx  <= '0;
            r_wd      <= '0;
            r_cf      <= '0;
            r_dr      <= '0;
            r_abort   <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            if (w_cnt_en) begin
                if (w_ret_ok) begin
                    r_pass[w_tail.cls] <= sat_inc(r_pass[w_tail.cls]);
                    r_total            <= sat_inc(r_total);
                    r_cf               <= '0;
                end
                if (w_ret_bad) begin
                    r_fail[w_tail.cls] <= sat_inc(r_fail[w_tail.cls]);
                    r_fcnt             <= sat_inc(r_fcnt);
                    r_total            <= sat_inc(r_total);
                    if (r_cf != CF_W'(MAX_CFAIL)) begin
                        r_cf <= r_cf + 1'b1;
                    end
                    // fail_cnt only returns to zero on a new run
                    if (r_fcnt == '0) begin
                        r_ff_inst <= w_tail.inst;
                        r_ff_idx  <= r_total;
                    end
                end
                if (w_spur) begin
                    r_spur <= sat_inc(r_spur);
                end
            end
            if (w_wd_en) begin
                r_wd <= w_tail.vld ? '0 : r_wd + 1'b1;
            end
            r_dr <= w_dr_en ? r_dr + 1'b1 : '0;
            if (w_cf_hit) r_abort <= 1'b1;
            if (w_wd_hit) r_tmo   <= 1'b1;
        end
    end

    assign cls_pass        = r_pass[cls_sel];
    assign cls_fail        = r_fail[cls_sel];
    assign total_cnt       = r_total;
    assign fail_cnt        = r_fcnt;
    assign spur_cnt        = r_spur;
    assign first_fail_inst = r_ff_inst;
    assign first_fail_idx  = r_ff_idx;
    assign busy            = (r_st == ST_RUN) | (r_st == ST_DRAIN);
    assign done            = (r_st == ST_DONE);
    assign abort           = r_abort;
    assign timeout         = r_tmo;
    assign all_pass        = done & (r_fcnt == '0) & (r_spur == '0)
                           & ~r_abort & ~r_tmo;

endmodule
